// File: rtl/wb8_bus_arbiter2_pkg.sv
// Shared constants for the two-master 8-bit Wishbone arbiter: bus widths,
// state encoding and the arbitration pick used from IDLE.
package wb8_bus_arbiter2_pkg;

  localparam int WB8_DAT_W = 8;
  localparam int WB8_ADR_W = 32;

  // One-hot owner encoding so the state register doubles as the grant vector.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  localparam logic [WB8_DAT_W-1:0] WB8_TIMEOUT_DAT = 8'hFF;

  // Round-robin pick: on a tie the master that did not own the bus last wins.
  function automatic logic [1:0] arb_pick(input logic cyc0, input logic cyc1,
                                          input logic last_owner);
    if (cyc0 && cyc1)
      return last_owner ? ST_OWN0 : ST_OWN1;
    else if (cyc0)
      return ST_OWN0;
    else if (cyc1)
      return ST_OWN1;
    else
      return ST_IDLE;
  endfunction

endpackage

// File: rtl/wb8_bus_arbiter2_watchdog.sv
// Per-beat stall counter; raises o_force for one cycle when an unacknowledged
// strobe has waited TIMEOUT cycles so the arbiter can complete it locally.
module wb8_watchdog
  import wb8_bus_arbiter2_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  input  logic i_clr,
  output logic o_force
);

  localparam logic [TIMEOUT_W-1:0] LP_LIMIT = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] LP_MAX   = {TIMEOUT_W{1'b1}};

  logic [TIMEOUT_W-1:0] r_cnt;

  // A real ACK in the limit cycle masks the forced completion.
  assign o_force = (TIMEOUT > 0) && i_active && i_stb && !i_ack && (r_cnt == LP_LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (!i_active || i_clr || !i_stb || i_ack || o_force)
      r_cnt <= '0;
    else if (r_cnt != LP_MAX)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/wb8_bus_arbiter2.sv
// Two-master round-robin arbiter for the 8-bit Wishbone slave bus, with a
// per-beat watchdog that completes strobes a slave never acknowledges.
//
// state   | meaning
// IDLE    | no owner; S_* quiet; arbitrate on M0/M1 CYC
// OWN0    | M0 owns the bus until it drops CYC
// OWN1    | M1 owns the bus until it drops CYC
module wb8_bus_arbiter2
  import wb8_bus_arbiter2_pkg::*;
#(
  parameter int                    TIMEOUT     = 255,
  parameter int                    TIMEOUT_W   = 8,
  parameter logic [WB8_DAT_W-1:0]  TIMEOUT_DAT = WB8_TIMEOUT_DAT
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic [WB8_ADR_W-1:0] M0_ADR_I,
  input  logic [WB8_DAT_W-1:0] M0_DAT_I,
  input  logic                 M0_CYC_I,
  input  logic                 M0_STB_I,
  input  logic                 M0_WE_I,
  output logic [WB8_DAT_W-1:0] M0_DAT_O,
  output logic                 M0_ACK_O,
  input  logic [WB8_ADR_W-1:0] M1_ADR_I,
  input  logic [WB8_DAT_W-1:0] M1_DAT_I,
  input  logic                 M1_CYC_I,
  input  logic                 M1_STB_I,
  input  logic                 M1_WE_I,
  output logic [WB8_DAT_W-1:0] M1_DAT_O,
  output logic                 M1_ACK_O,
  output logic [WB8_ADR_W-1:0] S_ADR_O,
  output logic [WB8_DAT_W-1:0] S_DAT_O,
  output logic                 S_CYC_O,
  output logic                 S_STB_O,
  output logic                 S_WE_O,
  input  logic [WB8_DAT_W-1:0] S_DAT_I,
  input  logic                 S_ACK_I,
  input  logic                 I_timeout_clr,
  output logic                 O_timeout,
  output logic [1:0]           O_grant
);

  logic [1:0]           r_state;
  logic                 r_last_owner;
  logic                 r_timeout;
  logic [1:0]           w_state_nxt;
  logic                 w_state_chg;
  logic                 w_own0;
  logic                 w_own1;
  logic                 w_force;
  logic                 w_m_cyc;
  logic                 w_m_stb;
  logic                 w_m_we;
  logic [WB8_ADR_W-1:0] w_m_adr;
  logic [WB8_DAT_W-1:0] w_m_dat;
  logic [WB8_DAT_W-1:0] w_rd_dat;

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = arb_pick(M0_CYC_I, M1_CYC_I, r_last_owner);
      ST_OWN0: if (!M0_CYC_I) w_state_nxt = ST_IDLE;
      ST_OWN1: if (!M1_CYC_I) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_state_chg = (w_state_nxt != r_state);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_own0 && !M0_CYC_I)
        r_last_owner <= 1'b0;
      else if (w_own1 && !M1_CYC_I)
        r_last_owner <= 1'b1;
    end
  end

  // Set wins over a simultaneous clear.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I)
      r_timeout <= 1'b0;
    else if (w_force)
      r_timeout <= 1'b1;
    else if (I_timeout_clr)
      r_timeout <= 1'b0;
  end

  wb8_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .i_clk    (CLK_I),
    .i_rst_n  (RST_I),
    .i_active (w_own0 | w_own1),
    .i_stb    (w_m_stb),
    .i_ack    (S_ACK_I),
    .i_clr    (w_state_chg),
    .o_force  (w_force)
  );

  // Owner select; everything reads as zero while idle.
  always_comb begin
    w_m_cyc = 1'b0;
    w_m_stb = 1'b0;
    w_m_we  = 1'b0;
    w_m_adr = '0;
    w_m_dat = '0;
    if (w_own0) begin
      w_m_cyc = M0_CYC_I;
      w_m_stb = M0_STB_I;
      w_m_we  = M0_WE_I;
      w_m_adr = M0_ADR_I;
      w_m_dat = M0_DAT_I;
    end else if (w_own1) begin
      w_m_cyc = M1_CYC_I;
      w_m_stb = M1_STB_I;
      w_m_we  = M1_WE_I;
      w_m_adr = M1_ADR_I;
      w_m_dat = M1_DAT_I;
    end
  end

  assign w_rd_dat = w_force ? TIMEOUT_DAT : S_DAT_I;

  assign S_ADR_O  = w_m_adr;
  assign S_DAT_O  = w_m_dat;
  assign S_CYC_O  = w_m_cyc;
  assign S_WE_O   = w_m_we;
  assign S_STB_O  = w_m_stb & ~w_force;

  assign M0_ACK_O = w_own0 & (S_ACK_I | w_force);
  assign M1_ACK_O = w_own1 & (S_ACK_I | w_force);
  assign M0_DAT_O = w_own0 ? w_rd_dat : '0;
  assign M1_DAT_O = w_own1 ? w_rd_dat : '0;

  assign O_timeout = r_timeout;
  assign O_grant   = r_state;

endmodule

// File: tb/tb_wb8_bus_arbiter2.sv
// Scoreboard bench for wb8_bus_arbiter2: two master drivers, a wait-state ROM
// slave, and a monitor that pops expected responses whenever an ACK appears.
module tb_wb8_bus_arbiter2;

  localparam int TO     = 4;
  localparam int BUDGET = 300;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [31:0] M0_ADR_I, M1_ADR_I, S_ADR_O;
  logic [7:0]  M0_DAT_I, M1_DAT_I, M0_DAT_O, M1_DAT_O, S_DAT_O, S_DAT_I;
  logic        M0_CYC_I, M0_STB_I, M0_WE_I, M0_ACK_O;
  logic        M1_CYC_I, M1_STB_I, M1_WE_I, M1_ACK_O;
  logic        S_CYC_O, S_STB_O, S_WE_O, S_ACK_I;
  logic        I_timeout_clr, O_timeout;
  logic [1:0]  O_grant;

  always #5 CLK_I = ~CLK_I;

  wb8_bus_arbiter2 #(.TIMEOUT(TO), .TIMEOUT_W(8), .TIMEOUT_DAT(8'hFF)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_CYC_I(M0_CYC_I), .M0_STB_I(M0_STB_I),
    .M0_WE_I(M0_WE_I), .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O),
    .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_CYC_I(M1_CYC_I), .M1_STB_I(M1_STB_I),
    .M1_WE_I(M1_WE_I), .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O),
    .S_ADR_O(S_ADR_O), .S_DAT_O(S_DAT_O), .S_CYC_O(S_CYC_O), .S_STB_O(S_STB_O),
    .S_WE_O(S_WE_O), .S_DAT_I(S_DAT_I), .S_ACK_I(S_ACK_I),
    .I_timeout_clr(I_timeout_clr), .O_timeout(O_timeout), .O_grant(O_grant)
  );

  // ROM-like slave: data is a fixed function of the address, and it inserts
  // adr[10:8]+2 wait states counted from the first strobed cycle.
  function automatic int lat_of(input logic [31:0] a);
    return int'(a[10:8]) + 2;
  endfunction

  int slv_cnt;
  always @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) slv_cnt <= 0;
    else if (S_STB_O && !S_ACK_I) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end
  assign S_ACK_I = S_CYC_O && (slv_cnt == lat_of(S_ADR_O));
  assign S_DAT_I = S_ADR_O[7:0] ^ 8'h4A;

  typedef struct {
    logic [7:0] dat;
    bit         forced;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] glog[$];
  int         gaps[$];
  int n_cmp = 0;
  int n_bad = 0;
  int last_wait[2];

  // Reference: a beat is withdrawn exactly when the slave needs more stall
  // cycles than the watchdog limit; otherwise the slave's own data comes back.
  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.forced = (TO > 0) && (lat_of(a) > TO);
    e.dat    = e.forced ? 8'hFF : (a[7:0] ^ 8'h4A);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic drv(input int m, input logic cyc, input logic stb, input logic we,
                     input logic [31:0] a, input logic [7:0] d);
    if (m == 0) begin
      M0_CYC_I = cyc; M0_STB_I = stb; M0_WE_I = we; M0_ADR_I = a; M0_DAT_I = d;
    end else begin
      M1_CYC_I = cyc; M1_STB_I = stb; M1_WE_I = we; M1_ADR_I = a; M1_DAT_I = d;
    end
  endtask

  function automatic logic ack_of(input int m);
    return (m == 0) ? M0_ACK_O : M1_ACK_O;
  endfunction

  // Called just after a rising edge; returns just after a rising edge with
  // CYC having been low for one full edge.
  task automatic run_burst(input int m, input int nbeats, input logic [31:0] base, input bit rnd);
    logic [31:0] a;
    logic        we;
    int          n;
    for (int b = 0; b < nbeats; b++) begin
      a  = rnd ? $urandom : base + 32'(b);
      we = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rnd && b > 0 && $urandom_range(0, 1) == 1) begin
        drv(m, 1'b1, 1'b0, 1'b0, a, 8'h00);
        @(posedge CLK_I); #1;
      end
      drv(m, 1'b1, 1'b1, we, a, 8'($urandom));
      if (m == 0) q0.push_back(model(a)); else q1.push_back(model(a));
      n = 0;
      do begin
        @(negedge CLK_I);
        n++;
      end while (!ack_of(m) && n < BUDGET);
      last_wait[m] = n;
      if (!ack_of(m)) fail($sformatf("ack_wait_m%0d", m));
      @(posedge CLK_I); #1;
    end
    drv(m, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    @(posedge CLK_I); #1;
  endtask

  // Monitor: scoreboard pops, sticky-flag model, grant-sequence log.
  initial begin
    exp_t       e;
    bit         f;
    logic [1:0] g_prev;
    int         idle_n;
    bit         m_sticky;
    g_prev = 2'b00; idle_n = 0; m_sticky = 0;
    forever begin
      @(negedge CLK_I);
      if (!RST_I) begin
        m_sticky = 0; g_prev = 2'b00; idle_n = 0;
      end else begin
        f = 0;
        chk("o_timeout", O_timeout, m_sticky);
        chk("direct_handoff", (g_prev != 2'b00 && O_grant != 2'b00 && O_grant != g_prev), 0);
        if (O_grant != 2'b01) chk("m0_quiet", {M0_ACK_O, M0_DAT_O}, 0);
        if (O_grant != 2'b10) chk("m1_quiet", {M1_ACK_O, M1_DAT_O}, 0);
        if (M0_ACK_O) begin
          if (q0.size() == 0) fail("m0_unexpected_ack");
          else begin
            e = q0.pop_front();
            chk("m0_dat", M0_DAT_O, e.dat);
            chk("m0_stb_on_ack", S_STB_O, !e.forced);
            f |= e.forced;
          end
        end
        if (M1_ACK_O) begin
          if (q1.size() == 0) fail("m1_unexpected_ack");
          else begin
            e = q1.pop_front();
            chk("m1_dat", M1_DAT_O, e.dat);
            chk("m1_stb_on_ack", S_STB_O, !e.forced);
            f |= e.forced;
          end
        end
        m_sticky = f ? 1'b1 : (I_timeout_clr ? 1'b0 : m_sticky);
        if (O_grant != g_prev && O_grant != 2'b00) begin
          glog.push_back(O_grant);
          gaps.push_back(idle_n);
        end
        if (O_grant == 2'b00) idle_n++; else idle_n = 0;
        g_prev = O_grant;
      end
    end
  end

  task automatic do_reset();
    RST_I = 1'b0;
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
  endtask

  initial begin
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    I_timeout_clr = 1'b0;
    last_wait[0] = 0; last_wait[1] = 0;
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("rst_grant", O_grant, 2'b00);
    chk("rst_s_ctl", {S_CYC_O, S_STB_O, S_WE_O}, 0);
    chk("rst_s_adr", S_ADR_O, 0);
    chk("rst_acks", {M0_ACK_O, M1_ACK_O, M0_DAT_O, M1_DAT_O}, 0);
    chk("rst_timeout", O_timeout, 0);
    @(posedge CLK_I); #1;
    RST_I = 1'b1;

    // Single M0 read with 2 wait states; grant one cycle after CYC.
    fork
      run_burst(0, 1, 32'h0000_0010, 1'b0);
      begin
        @(negedge CLK_I); chk("t1_grant_lat", O_grant, 2'b00);
        @(negedge CLK_I); chk("t1_grant", O_grant, 2'b01);
      end
    join

    // Simultaneous request straight after reset.
    do_reset();
    glog.delete(); gaps.delete();
    fork
      run_burst(0, 1, 32'h20, 1'b0);
      run_burst(1, 1, 32'h30, 1'b0);
    join
    chk("t2_nbursts", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t2_first", glog[0], 2'b01);
      chk("t2_second", glog[1], 2'b10);
      chk("t2_gap", gaps[1], 1);
    end

    // Continuous contention: strict alternation with one idle cycle.
    glog.delete(); gaps.delete();
    fork
      begin repeat (3) run_burst(0, 1, 32'h40, 1'b0); end
      begin repeat (3) run_burst(1, 1, 32'h50, 1'b0); end
    join
    chk("t3_nbursts", glog.size(), 6);
    for (int i = 0; i < glog.size() && i < 6; i++) begin
      chk($sformatf("t3_grant%0d", i), glog[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk($sformatf("t3_gap%0d", i), gaps[i], 1);
    end

    // Hung slave on M1: forced completion on the 5th stalled cycle.
    run_burst(1, 1, 32'h0000_0700, 1'b0);
    chk("t4_wait", last_wait[1], 6);
    chk("t4_flag", O_timeout, 1);
    I_timeout_clr = 1'b1;
    @(posedge CLK_I); #1;
    I_timeout_clr = 1'b0;
    @(negedge CLK_I);
    chk("t4_clr", O_timeout, 0);
    @(posedge CLK_I); #1;

    // Slave ACK arrives on exactly the limit cycle.
    run_burst(0, 1, 32'h0000_0200, 1'b0);
    chk("t5_wait", last_wait[0], 6);
    chk("t5_flag", O_timeout, 0);

    // Randomized multi-beat bursts from both masters plus random flag clears.
    fork
      begin
        for (int k = 0; k < 25; k++) begin
          run_burst(0, $urandom_range(1, 3), 32'h0, 1'b1);
          repeat ($urandom_range(0, 3)) @(posedge CLK_I);
          #1;
        end
      end
      begin
        for (int k = 0; k < 25; k++) begin
          run_burst(1, $urandom_range(1, 3), 32'h0, 1'b1);
          repeat ($urandom_range(0, 3)) @(posedge CLK_I);
          #1;
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(5, 20)) @(posedge CLK_I);
          #1 I_timeout_clr = 1'b1;
          @(posedge CLK_I);
          #1 I_timeout_clr = 1'b0;
        end
      end
    join
    chk("rand_drained", q0.size() + q1.size(), 0);

    // Asynchronous reset mid-strobe while M0 owns the bus.
    @(posedge CLK_I); #1;
    drv(0, 1'b1, 1'b1, 1'b0, 32'h0000_0700, 8'h00);
    @(posedge CLK_I);
    @(posedge CLK_I); #2;
    chk("t6_pre_stb", {S_CYC_O, S_STB_O}, 2'b11);
    RST_I = 1'b0;
    #1;
    chk("t6_async_s", {S_CYC_O, S_STB_O}, 2'b00);
    chk("t6_async_ack", M0_ACK_O, 0);
    chk("t6_async_grant", O_grant, 2'b00);
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    @(posedge CLK_I); #1;
    RST_I = 1'b1;
    drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    drv(1, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00);
    @(negedge CLK_I);
    chk("t6_idle_after", O_grant, 2'b00);
    @(negedge CLK_I);
    chk("t6_tie_m0", O_grant, 2'b01);
    @(posedge CLK_I); #1;
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00);
    repeat (4) @(posedge CLK_I);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit reached at %0t", $time);
    $fatal(1);
  end

endmodule
